// File: rtl/head_core_array_mem_ctrl_pkg.sv
// Shared definitions for the head core-array memory controller.
// host_addr layout (MSB first): out-of-array flag, broadcast flag,
// core select, per-core cmem address. Positions below are counted down
// from the MSB (bit index = HA - *_FROM_TOP).
package head_core_array_mem_ctrl_pkg;

    localparam int OOA_FROM_TOP   = 1;
    localparam int BCAST_FROM_TOP = 2;

    function automatic int host_addr_width(input int sel_w, input int addr_w);
        return addr_w + sel_w + 2;
    endfunction

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_WAIT_RSP = 2'd1,
        RD_RESP     = 2'd2
    } rd_state_e;

    typedef enum logic {
        FIN_IDLE  = 1'b0,
        FIN_ARMED = 1'b1
    } fin_state_e;

endpackage

// File: rtl/head_core_array_mem_ctrl_finish_agg.sv
// head_core_finish_agg: start-armed finish aggregation across the core array.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               arm (or re-arm) and clear all sticky flags
//   core_finish_array   per-core finish pulses (counted only while armed)
//   core_en_mask        1 = core must finish; 0 = core counts as complete
//   finish              one-cycle pulse when every core is complete
//   finish_flags        sticky per-core finish status
module head_core_finish_agg
    import head_core_array_mem_ctrl_pkg::*;
#(
    parameter int CORE_NUM = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CORE_NUM-1:0] core_finish_array,
    input  logic [CORE_NUM-1:0] core_en_mask,
    output logic                finish,
    output logic [CORE_NUM-1:0] finish_flags
);

    fin_state_e          state_q;
    logic [CORE_NUM-1:0] flags_q;
    logic                finish_q;

    // Live pulses are folded in so finish lands the cycle after the last pulse.
    logic all_done;
    logic all_masked;
    assign all_done   = &(flags_q | core_finish_array | ~core_en_mask);
    assign all_masked = ~|core_en_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FIN_IDLE;
            flags_q  <= '0;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            if (start) begin
                // start wins over any completion seen in the same cycle
                flags_q <= '0;
                if (all_masked) begin
                    finish_q <= 1'b1;
                    state_q  <= FIN_IDLE;
                end else begin
                    state_q  <= FIN_ARMED;
                end
            end else if (state_q == FIN_ARMED) begin
                if (all_done) begin
                    finish_q <= 1'b1;
                    flags_q  <= '0;
                    state_q  <= FIN_IDLE;
                end else begin
                    flags_q  <= flags_q | core_finish_array;
                end
            end
        end
    end

    assign finish       = finish_q;
    assign finish_flags = flags_q;

endmodule

// File: rtl/head_core_array_mem_ctrl.sv
// head_core_array_mem_ctrl: host-side memory/control front end for the core
// array. Routes host writes (unicast or masked broadcast) and single
// outstanding reads to CORE_NUM cores, reports read errors/timeouts, and
// aggregates per-core finish pulses.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   host_addr/wdata/wen/ren    host request; host_ready = accepted this cycle
//   host_rdata/rvld/rerr       one-cycle read response, rerr qualifies it
//   core_mem_*_array           registered per-core memory strobes/data
//   core_mem_rdata/rvld_array  per-core read return
//   core_en_mask               per-core participation
//   start/core_finish_array    finish aggregation control and inputs
//   finish/finish_flags        array-done pulse and sticky per-core status
module head_core_array_mem_ctrl
    import head_core_array_mem_ctrl_pkg::*;
#(
    parameter  int CORE_NUM        = 16,
    parameter  int CORE_SEL_WIDTH  = 4,
    parameter  int CMEM_ADDR_WIDTH = 14,
    parameter  int DATA_WIDTH      = 16,
    parameter  int RD_TIMEOUT      = 63,
    localparam int HA              = host_addr_width(CORE_SEL_WIDTH, CMEM_ADDR_WIDTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [HA-1:0]                       host_addr,
    input  logic [DATA_WIDTH-1:0]               host_wdata,
    input  logic                                host_wen,
    input  logic                                host_ren,
    output logic                                host_ready,
    output logic [DATA_WIDTH-1:0]               host_rdata,
    output logic                                host_rvld,
    output logic                                host_rerr,
    output logic [CORE_NUM*CMEM_ADDR_WIDTH-1:0] core_mem_addr_array,
    output logic [CORE_NUM*DATA_WIDTH-1:0]      core_mem_wdata_array,
    output logic [CORE_NUM-1:0]                 core_mem_wen_array,
    output logic [CORE_NUM-1:0]                 core_mem_ren_array,
    input  logic [CORE_NUM*DATA_WIDTH-1:0]      core_mem_rdata_array,
    input  logic [CORE_NUM-1:0]                 core_mem_rvld_array,
    input  logic [CORE_NUM-1:0]                 core_en_mask,
    input  logic                                start,
    input  logic [CORE_NUM-1:0]                 core_finish_array,
    output logic                                finish,
    output logic [CORE_NUM-1:0]                 finish_flags
);

    localparam int SELN = 2 ** CORE_SEL_WIDTH;
    localparam int TW   = $clog2(RD_TIMEOUT + 1);
    localparam logic [CORE_SEL_WIDTH:0] SEL_LIM = (CORE_SEL_WIDTH + 1)'(CORE_NUM);

    // ---------------- request decode ----------------
    logic                       ooa, bcast;
    logic [CORE_SEL_WIDTH-1:0]  sel;
    logic [CMEM_ADDR_WIDTH-1:0] caddr;
    assign ooa   = host_addr[HA-OOA_FROM_TOP];
    assign bcast = host_addr[HA-BCAST_FROM_TOP];
    assign sel   = host_addr[CMEM_ADDR_WIDTH +: CORE_SEL_WIDTH];
    assign caddr = host_addr[CMEM_ADDR_WIDTH-1:0];

    // Mask padded to the full select range so out-of-range selects read 0.
    logic [SELN-1:0] mask_pad;
    always_comb begin
        mask_pad = '0;
        mask_pad[CORE_NUM-1:0] = core_en_mask;
    end

    logic host_ready_q;
    logic accept, wr_acc, rd_acc, rd_legal;
    assign accept   = (host_wen | host_ren) & host_ready_q & ~ooa;
    assign wr_acc   = accept & host_wen;
    assign rd_acc   = accept & host_ren & ~host_wen;  // write wins, read dropped
    assign rd_legal = ~bcast & ({1'b0, sel} < SEL_LIM) & mask_pad[sel];

    // ---------------- per-core registered outputs ----------------
    logic [CORE_NUM-1:0]                      wen_d, ren_d, wen_q, ren_q;
    logic [CORE_NUM-1:0][CMEM_ADDR_WIDTH-1:0] addr_q;
    logic [CORE_NUM-1:0][DATA_WIDTH-1:0]      wdata_q;
    logic [CORE_NUM-1:0][DATA_WIDTH-1:0]      rdata_in;
    assign rdata_in = core_mem_rdata_array;

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
        logic hit_sel;
        assign hit_sel  = (sel == CORE_SEL_WIDTH'(i));
        assign wen_d[i] = wr_acc & core_en_mask[i] & (bcast | hit_sel);
        assign ren_d[i] = rd_acc & rd_legal & hit_sel;

        // Address/data hold their last value between accesses to this core.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
            end else begin
                if (wen_d[i] | ren_d[i]) addr_q[i]  <= caddr;
                if (wen_d[i])            wdata_q[i] <= host_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q <= '0;
            ren_q <= '0;
        end else begin
            wen_q <= wen_d;
            ren_q <= ren_d;
        end
    end

    assign core_mem_addr_array  = addr_q;
    assign core_mem_wdata_array = wdata_q;
    assign core_mem_wen_array   = wen_q;
    assign core_mem_ren_array   = ren_q;

    // ---------------- read FSM ----------------
    rd_state_e                 rd_state_q;
    logic [CORE_SEL_WIDTH-1:0] rd_sel_q;
    logic                      rd_err_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;
    logic [TW-1:0]             tcnt_q;
    logic                      host_rvld_q, host_rerr_q;
    logic [DATA_WIDTH-1:0]     host_rdata_q;

    // Only the outstanding core's return is looked at; others are ignored.
    logic                  sel_rvld;
    logic [DATA_WIDTH-1:0] sel_rdata;
    always_comb begin
        sel_rvld  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            if (rd_sel_q == CORE_SEL_WIDTH'(i)) begin
                sel_rvld  = core_mem_rvld_array[i];
                sel_rdata = rdata_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q   <= RD_IDLE;
            rd_sel_q     <= '0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
            tcnt_q       <= '0;
            host_ready_q <= 1'b1;
            host_rvld_q  <= 1'b0;
            host_rerr_q  <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_rvld_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_acc) begin
                        rd_sel_q     <= sel;
                        host_ready_q <= 1'b0;
                        if (rd_legal) begin
                            tcnt_q     <= '0;
                            rd_state_q <= RD_WAIT_RSP;
                        end else begin
                            rd_err_q   <= 1'b1;
                            rd_data_q  <= '0;
                            rd_state_q <= RD_RESP;
                        end
                    end
                end
                RD_WAIT_RSP: begin
                    if (sel_rvld) begin
                        rd_err_q   <= 1'b0;
                        rd_data_q  <= sel_rdata;
                        rd_state_q <= RD_RESP;
                    end else if (tcnt_q == TW'(RD_TIMEOUT)) begin
                        rd_err_q   <= 1'b1;
                        rd_data_q  <= '0;
                        rd_state_q <= RD_RESP;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                RD_RESP: begin
                    host_rvld_q  <= 1'b1;
                    host_rerr_q  <= rd_err_q;
                    host_rdata_q <= rd_data_q;
                    host_ready_q <= 1'b1;
                    rd_state_q   <= RD_IDLE;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign host_ready = host_ready_q;
    assign host_rvld  = host_rvld_q;
    assign host_rerr  = host_rerr_q;
    assign host_rdata = host_rdata_q;

    // ---------------- finish aggregation ----------------
    head_core_finish_agg #(
        .CORE_NUM(CORE_NUM)
    ) u_finish_agg (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .core_finish_array(core_finish_array),
        .core_en_mask     (core_en_mask),
        .finish           (finish),
        .finish_flags     (finish_flags)
    );

endmodule

// File: tb/tb_head_core_array_mem_ctrl.sv
module tb_head_core_array_mem_ctrl;

    localparam int CN = 16, SW = 4, AW = 14, DW = 16, TO = 63;
    localparam int HA = AW + SW + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [HA-1:0]    host_addr = '0;
    logic [DW-1:0]    host_wdata = '0;
    logic             host_wen = 1'b0, host_ren = 1'b0;
    logic             host_ready, host_rvld, host_rerr;
    logic [DW-1:0]    host_rdata;
    logic [CN*AW-1:0] core_mem_addr_array;
    logic [CN*DW-1:0] core_mem_wdata_array;
    logic [CN-1:0]    core_mem_wen_array, core_mem_ren_array;
    logic [CN*DW-1:0] core_mem_rdata_array = '0;
    logic [CN-1:0]    core_mem_rvld_array = '0;
    logic [CN-1:0]    core_en_mask = '1;
    logic             start = 1'b0;
    logic [CN-1:0]    core_finish_array = '0;
    logic             finish;
    logic [CN-1:0]    finish_flags;

    head_core_array_mem_ctrl #(
        .CORE_NUM(CN), .CORE_SEL_WIDTH(SW), .CMEM_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .RD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_wen(host_wen), .host_ren(host_ren), .host_ready(host_ready),
        .host_rdata(host_rdata), .host_rvld(host_rvld), .host_rerr(host_rerr),
        .core_mem_addr_array(core_mem_addr_array),
        .core_mem_wdata_array(core_mem_wdata_array),
        .core_mem_wen_array(core_mem_wen_array),
        .core_mem_ren_array(core_mem_ren_array),
        .core_mem_rdata_array(core_mem_rdata_array),
        .core_mem_rvld_array(core_mem_rvld_array),
        .core_en_mask(core_en_mask), .start(start),
        .core_finish_array(core_finish_array),
        .finish(finish), .finish_flags(finish_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic flag_bad(input string nm, input int want_cyc);
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cyc %0d: event expected at cyc %0d (-1 = none expected)", nm, cyc, want_cyc);
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        int            cyc;
        logic [CN-1:0] wen;
        logic [CN-1:0] ren;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } core_ev_t;

    typedef struct {
        int            cyc;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    core_ev_t core_q[$];
    rsp_t     rsp_q[$];
    int       fin_q[$];

    // ---------------- monitor ----------------
    initial begin
        core_ev_t e;
        rsp_t     r;
        int       fc;
        forever begin
            @(negedge clk);
            while (core_q.size() > 0 && core_q[0].cyc < cyc) begin
                e = core_q.pop_front();
                flag_bad("core_strobe_missing", e.cyc);
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                r = rsp_q.pop_front();
                flag_bad("host_rvld_missing", r.cyc);
            end
            while (fin_q.size() > 0 && fin_q[0] < cyc) begin
                fc = fin_q.pop_front();
                flag_bad("finish_missing", fc);
            end
            if (|core_mem_wen_array || |core_mem_ren_array) begin
                if (core_q.size() == 0) flag_bad("core_strobe_spurious", -1);
                else begin
                    e = core_q.pop_front();
                    chk("core_strobe_cyc", cyc, e.cyc);
                    chk("core_wen", core_mem_wen_array, e.wen);
                    chk("core_ren", core_mem_ren_array, e.ren);
                    for (int i = 0; i < CN; i++) begin
                        if (e.wen[i] || e.ren[i])
                            chk("core_addr", core_mem_addr_array[i*AW +: AW], e.addr);
                        if (e.wen[i])
                            chk("core_wdata", core_mem_wdata_array[i*DW +: DW], e.data);
                    end
                end
            end
            if (host_rvld) begin
                if (rsp_q.size() == 0) flag_bad("host_rvld_spurious", -1);
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_cyc", cyc, r.cyc);
                    chk("rsp_rerr", host_rerr, r.err);
                    chk("rsp_rdata", host_rdata, r.data);
                end
            end
            if (finish) begin
                if (fin_q.size() == 0) flag_bad("finish_spurious", -1);
                else begin
                    fc = fin_q.pop_front();
                    chk("finish_cyc", cyc, fc);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete @cyc %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One host request. d = cycles from the core's ren to its rvld (-1: never).
    // Reference rules: write targets = bcast ? mask : mask & onehot(sel);
    // legal read response 2 cycles after rvld if it arrives within RD_TIMEOUT
    // cycles of WAIT entry, else timeout error; illegal read responds 2 cycles
    // after acceptance.
    task automatic do_req(input logic ooa, input logic bc, input logic [SW-1:0] sel,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic wen, input logic ren, input int d,
                          input logic [DW-1:0] rd);
        int            t, rc, j;
        logic [CN-1:0] tgt;
        logic          legal, ok, hit;
        core_ev_t      e;
        rsp_t          r;
        t = cyc;
        host_addr  = {ooa, bc, sel, a};
        host_wdata = wd;
        host_wen   = wen;
        host_ren   = ren;
        if (!ooa && wen) begin
            tgt = bc ? core_en_mask : (core_en_mask & (CN'(1) << sel));
            if (tgt != '0) begin
                e.cyc = t + 1; e.wen = tgt; e.ren = '0; e.addr = a; e.data = wd;
                core_q.push_back(e);
            end
        end
        legal = !bc && core_en_mask[sel];
        hit   = (d >= 0 && d <= TO);
        if (!ooa && !wen && ren) begin
            if (!legal) begin
                rc = t + 2;
                r.cyc = rc; r.err = 1'b1; r.data = '0;
            end else begin
                e.cyc = t + 1; e.wen = '0; e.ren = CN'(1) << sel; e.addr = a; e.data = '0;
                core_q.push_back(e);
                rc = hit ? t + 3 + d : t + 3 + TO;
                r.cyc = rc; r.err = !hit; r.data = hit ? rd : '0;
            end
            rsp_q.push_back(r);
        end
        tick();
        host_wen = 1'b0;
        host_ren = 1'b0;
        if (ooa || wen || !ren) return;
        ok = 1'b1;
        while (cyc < rc) begin
            if (host_ready !== 1'b0) ok = 1'b0;
            core_mem_rvld_array  = '0;
            core_mem_rdata_array = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (legal && d >= 0 && cyc == t + 1 + d) begin
                core_mem_rvld_array[sel] = 1'b1;
                core_mem_rdata_array[int'(sel)*DW +: DW] = rd;
            end else if ($urandom_range(3) == 0) begin
                j = (int'(sel) + 1 + int'($urandom_range(CN - 2))) % CN;
                core_mem_rvld_array[j] = 1'b1;
            end
            // requests while busy must be ignored
            host_addr = {2'b00, SW'($urandom), AW'($urandom)};
            host_wen  = ($urandom_range(3) == 0);
            tick();
        end
        core_mem_rvld_array = '0;
        host_wen = 1'b0;
        chk("ready_low_while_busy", ok, 1'b1);
        chk("ready_back_at_rsp", host_ready, 1'b1);
    endtask

    // Finish aggregation: every enabled core must pulse after start.
    task automatic fin_seq(input logic [CN-1:0] m, input bit pre, input bit rearm, input bit ordered);
        int            lst[$];
        int            tmp, j, p, pre_core, last;
        logic [CN-1:0] fl, extra;
        core_en_mask = m;
        pre_core = -1;
        for (int i = 0; i < CN; i++) if (m[i]) lst.push_back(i);
        if (!ordered)
            for (int i = lst.size() - 1; i > 0; i--) begin
                j = int'($urandom_range(i));
                tmp = lst[i]; lst[i] = lst[j]; lst[j] = tmp;
            end
        if (pre && lst.size() > 0) begin
            pre_core = lst.pop_front();
            lst.push_back(pre_core);
            core_finish_array = CN'(1) << pre_core;
            tick();
            core_finish_array = '0;
            chk("flags_idle_pulse_ignored", finish_flags, '0);
        end
        start = 1'b1;
        if (m == '0) fin_q.push_back(cyc + 1);
        tick();
        start = 1'b0;
        chk("flags_after_start", finish_flags, '0);
        if (m == '0) begin
            tick();
            return;
        end
        fl = '0;
        for (int k = 0; k < lst.size(); k++) begin
            if (rearm && k == lst.size() / 2) begin
                rearm = 0;
                start = 1'b1;
                core_finish_array = CN'(1) << lst[0];
                tick();
                start = 1'b0;
                core_finish_array = '0;
                fl = '0;
                chk("flags_after_rearm", finish_flags, '0);
                k = -1;
                continue;
            end
            repeat ($urandom_range(2)) tick();
            last  = (k == lst.size() - 1);
            extra = ($urandom_range(2) == 0) ? (~m & CN'($urandom)) : '0;
            core_finish_array = (CN'(1) << lst[k]) | extra;
            fl = fl | core_finish_array;
            p = cyc;
            if (last) fin_q.push_back(p + 1);
            tick();
            core_finish_array = '0;
            if (last) begin
                core_finish_array = CN'(1) << lst[0];   // lands while finish is high
                tick();
                core_finish_array = '0;
                chk("flags_cleared_after_finish", finish_flags, '0);
                repeat (3) tick();
            end else begin
                chk("flags_accumulate", finish_flags, fl);
            end
        end
    endtask

    initial begin
        int t, k, d;
        repeat (3) tick();
        chk("rst_host_ready", host_ready, 1'b1);
        chk("rst_host_rvld", host_rvld, 1'b0);
        chk("rst_host_rerr", host_rerr, 1'b0);
        chk("rst_host_rdata", host_rdata, '0);
        chk("rst_wen", core_mem_wen_array, '0);
        chk("rst_ren", core_mem_ren_array, '0);
        chk("rst_addr0", core_mem_addr_array[AW-1:0], '0);
        chk("rst_wdata0", core_mem_wdata_array[DW-1:0], '0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_flags", finish_flags, '0);
        rst_n = 1'b1;
        tick();

        // directed
        core_en_mask = '1;
        do_req(0, 0, 4'd5, 14'h123, 16'hBEEF, 1, 0, 0, '0);
        core_en_mask = 16'h00FF;
        do_req(0, 1, 4'd0, 14'h03A, 16'h5555, 1, 0, 0, '0);
        do_req(0, 0, 4'd12, 14'h001, 16'h0002, 1, 0, 0, '0);
        do_req(0, 0, 4'd12, 14'h001, 16'h0000, 0, 1, 3, 16'h9999);
        core_en_mask = '1;
        do_req(0, 0, 4'd3, 14'h040, '0, 0, 1, 4, 16'h1234);
        do_req(0, 0, 4'd7, 14'h041, '0, 0, 1, TO + 1, 16'hAAAA);
        do_req(0, 0, 4'd9, 14'h042, '0, 0, 1, TO, 16'hC0DE);
        do_req(0, 0, 4'd2, 14'h043, '0, 0, 1, 0, 16'h0F0F);
        do_req(0, 1, 4'd0, 14'h000, '0, 0, 1, 0, '0);
        do_req(1, 0, 4'd2, 14'h011, 16'h1111, 1, 0, 0, '0);
        do_req(1, 0, 4'd2, 14'h011, '0, 0, 1, 0, 16'h2222);
        do_req(0, 0, 4'd6, 14'h007, 16'h0077, 1, 1, 0, 16'h3333);
        repeat (3) tick();

        // randomized
        for (int n = 0; n < 60; n++) begin
            core_en_mask = CN'($urandom | $urandom);
            k = int'($urandom_range(9));
            if (k <= 6) d = int'($urandom_range(8));
            else if (k == 7) d = TO;
            else if (k == 8) d = TO + 1;
            else d = -1;
            k = int'($urandom_range(9));
            do_req(k == 9, $urandom_range(5) == 0, SW'($urandom), AW'($urandom), DW'($urandom),
                   k <= 3 || k == 8, k >= 4, d, DW'($urandom));
            repeat ($urandom_range(2)) tick();
        end
        repeat (3) tick();

        // finish aggregation
        fin_seq(16'h7FFF, 0, 0, 1);
        fin_seq(16'hFFFF, 1, 0, 0);
        fin_seq(16'h0000, 0, 0, 0);
        for (int n = 0; n < 4; n++) fin_seq(CN'($urandom | 1), $urandom_range(1), n[0], 0);

        // reset while a read is waiting on its core
        core_en_mask = '1;
        begin
            core_ev_t e;
            t = cyc;
            host_addr = {2'b00, 4'd2, 14'h055};
            host_ren  = 1'b1;
            e.cyc = t + 1; e.wen = '0; e.ren = CN'(1) << 2; e.addr = 14'h055; e.data = '0;
            core_q.push_back(e);
            tick();
            host_ren = 1'b0;
            repeat (2) tick();
            rst_n = 1'b0;
            #1;
            chk("midread_rst_ready", host_ready, 1'b1);
            chk("midread_rst_rvld", host_rvld, 1'b0);
            repeat (2) tick();
            rst_n = 1'b1;
            core_mem_rvld_array[2] = 1'b1;
            repeat (3) tick();
            core_mem_rvld_array = '0;
            repeat (8) tick();
            chk("after_rst_ready", host_ready, 1'b1);
        end

        repeat (4) tick();
        chk("core_q_drained", core_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("fin_q_drained", fin_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
